// File: rtl/ej32_rs_ctl_if.sv
// Core and debug-host signal bundle for the eJ32 return-stack controller.
// master = core/host side, slave = controller.
interface ej32_rs_ctl_if #(
    parameter int unsigned DSZ = 32,
    parameter int unsigned SSZ = 10
);
    logic [2:0]     c_op;
    logic [DSZ-1:0] c_d;
    logic [SSZ-1:0] c_ofs;
    logic           c_rdy;
    logic [DSZ-1:0] r_o;
    logic           r_vld;
    logic           ld_vld;
    logic [DSZ-1:0] ld_d;
    logic [SSZ:0]   rp_o;
    logic           ovf;
    logic           unf;
    logic           h_req;
    logic           h_we;
    logic [SSZ-1:0] h_addr;
    logic [DSZ-1:0] h_wd;
    logic           h_ack;
    logic [DSZ-1:0] h_rd;

    modport master (
        output c_op, c_d, c_ofs, h_req, h_we, h_addr, h_wd,
        input  c_rdy, r_o, r_vld, ld_vld, ld_d, rp_o, ovf, unf, h_ack, h_rd
    );

    modport slave (
        input  c_op, c_d, c_ofs, h_req, h_we, h_addr, h_wd,
        output c_rdy, r_o, r_vld, ld_vld, ld_d, rp_o, ovf, unf, h_ack, h_rd
    );
endinterface

// File: rtl/ej32_rs_ctl.sv
// eJ32 return-stack controller: top-of-stack flop, BRAM spill store, and a
// core/host arbiter for the single BRAM port with host anti-starvation.
module ej32_rs_ctl #(
    parameter int unsigned DSZ   = 32,
    parameter int unsigned SSZ   = 10,
    parameter int unsigned HWAIT = 8
) (
    input logic         clk,
    input logic         rst,
    ej32_rs_ctl_if.slave bus
);
    localparam int unsigned CAP = 2 ** SSZ + 1;
    localparam int unsigned CW  = $clog2(HWAIT + 1) + 1;
    localparam logic [SSZ:0]   RP_FULL = (SSZ + 1)'(CAP);
    localparam logic [SSZ:0]   RP_ONE  = (SSZ + 1)'(1);
    localparam logic [SSZ-1:0] A1      = SSZ'(1);
    localparam logic [SSZ-1:0] A2      = SSZ'(2);
    localparam logic [CW-1:0]  HW_MAX  = CW'(HWAIT);
    localparam logic [CW-1:0]  HW_ONE  = CW'(1);

    localparam logic [2:0] OpPush = 3'd1;
    localparam logic [2:0] OpPop  = 3'd2;
    localparam logic [2:0] OpMove = 3'd3;
    localparam logic [2:0] OpLoad = 3'd4;

    typedef enum logic [1:0] {StIdle, StFill, StLoad, StHost} state_e;

    state_e         state_q, state_d;
    logic [SSZ:0]   rp_q, rp_d;
    logic [DSZ-1:0] top_q, top_d;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic           ld_vld_q, ld_vld_d;
    logic [DSZ-1:0] ld_d_q, ld_d_d;
    logic [DSZ-1:0] h_rd_q, h_rd_d;
    logic [CW-1:0]  hw_q, hw_d;

    logic [DSZ-1:0] mem [2**SSZ];
    logic [DSZ-1:0] rd_q;
    logic           mem_we, mem_re;
    logic [SSZ-1:0] mem_addr;
    logic [DSZ-1:0] mem_wd;

    logic           core_nop, force_grant, grant, accept;
    logic [SSZ-1:0] rp_lo;

    // Addresses are computed modulo 2**SSZ; the rp guards keep them in range.
    assign rp_lo       = rp_q[SSZ-1:0];
    assign core_nop    = !(bus.c_op inside {OpPush, OpPop, OpMove, OpLoad});
    assign force_grant = bus.h_req && (hw_q == HW_MAX);
    assign grant       = (state_q == StIdle) && bus.h_req && (core_nop || force_grant);
    assign accept      = (state_q == StIdle) && !force_grant;

    always_comb begin
        state_d  = state_q;
        rp_d     = rp_q;
        top_d    = top_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ld_vld_d = 1'b0;
        ld_d_d   = ld_d_q;
        h_rd_d   = h_rd_q;
        hw_d     = hw_q;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (bus.c_op)
                        OpPush, OpMove: begin
                            if (bus.c_op == OpMove && rp_q != '0) begin
                                top_d = bus.c_d;
                            end else if (rp_q == RP_FULL) begin
                                ovf_d = 1'b1;
                            end else begin
                                if (rp_q != '0) begin
                                    mem_we   = 1'b1;
                                    mem_addr = rp_lo - A1;
                                    mem_wd   = top_q;
                                end
                                top_d = bus.c_d;
                                rp_d  = rp_q + RP_ONE;
                            end
                        end
                        OpPop: begin
                            if (rp_q == '0) begin
                                unf_d = 1'b1;
                            end else if (rp_q == RP_ONE) begin
                                top_d = '0;
                                rp_d  = '0;
                            end else begin
                                mem_re   = 1'b1;
                                mem_addr = rp_lo - A2;
                                state_d  = StFill;
                            end
                        end
                        OpLoad: begin
                            if ({1'b0, bus.c_ofs} >= rp_q) begin
                                unf_d    = 1'b1;
                                ld_vld_d = 1'b1;
                                ld_d_d   = '0;
                            end else if (bus.c_ofs == '0) begin
                                ld_vld_d = 1'b1;
                                ld_d_d   = top_q;
                            end else begin
                                mem_re   = 1'b1;
                                mem_addr = rp_lo - A1 - bus.c_ofs;
                                state_d  = StLoad;
                            end
                        end
                        default: ;
                    endcase
                end
                // Grant only coincides with a NOP or a stalled core, so no port clash.
                if (grant) begin
                    mem_addr = bus.h_addr;
                    mem_wd   = bus.h_wd;
                    mem_we   = bus.h_we;
                    mem_re   = !bus.h_we;
                    state_d  = StHost;
                end
            end
            StFill: begin
                top_d   = rd_q;
                rp_d    = rp_q - RP_ONE;
                state_d = StIdle;
            end
            StLoad: begin
                ld_d_d  = rd_q;
                state_d = StIdle;
            end
            StHost: begin
                if (!bus.h_we) h_rd_d = rd_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (grant) begin
            hw_d = '0;
        end else if (bus.h_req && state_q != StHost && hw_q != HW_MAX) begin
            hw_d = hw_q + HW_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rp_q     <= '0;
            top_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ld_vld_q <= 1'b0;
            ld_d_q   <= '0;
            h_rd_q   <= '0;
            hw_q     <= '0;
        end else begin
            state_q  <= state_d;
            rp_q     <= rp_d;
            top_q    <= top_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            ld_vld_q <= ld_vld_d;
            ld_d_q   <= ld_d_d;
            h_rd_q   <= h_rd_d;
            hw_q     <= hw_d;
        end
    end

    // Block RAM: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wd;
        end else if (mem_re) begin
            rd_q <= mem[mem_addr];
        end
    end

    assign bus.c_rdy  = accept;
    assign bus.r_o    = top_q;
    assign bus.r_vld  = (state_q != StFill);
    assign bus.ld_vld = ld_vld_q || (state_q == StLoad);
    assign bus.ld_d   = (state_q == StLoad) ? rd_q : ld_d_q;
    assign bus.rp_o   = rp_q;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;
    assign bus.h_ack  = (state_q == StHost);
    assign bus.h_rd   = (state_q == StHost && !bus.h_we) ? rd_q : h_rd_q;
endmodule

// File: tb/tb_ej32_rs_ctl.sv
// Directed bench for ej32_rs_ctl with a 5-entry stack (SSZ=2) and HWAIT=3.
module tb_ej32_rs_ctl;
    localparam int unsigned DSZ = 32;
    localparam int unsigned SSZ = 2;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, MOVE = 3'd3, LOAD = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ej32_rs_ctl_if #(.DSZ(DSZ), .SSZ(SSZ)) bus ();

    ej32_rs_ctl #(.DSZ(DSZ), .SSZ(SSZ), .HWAIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] o, input logic [DSZ-1:0] d, input logic [SSZ-1:0] ofs);
        bus.c_op  = o;
        bus.c_d   = d;
        bus.c_ofs = ofs;
        tick();
        bus.c_op = NOP;
        #1;
    endtask

    int             pushed, low_at, ack_at;
    logic [DSZ-1:0] hrd;
    logic           acc;

    initial begin
        bus.c_op = NOP; bus.c_d = '0; bus.c_ofs = '0;
        bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wd = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_rp", bus.rp_o, 0);
        chk("rst_r", bus.r_o, 0);
        chk("rst_rvld", bus.r_vld, 1);
        chk("rst_crdy", bus.c_rdy, 1);
        chk("rst_ldvld", bus.ld_vld, 0);
        chk("rst_ldd", bus.ld_d, 0);
        chk("rst_flags", {bus.ovf, bus.unf}, 0);
        chk("rst_hack", bus.h_ack, 0);
        chk("rst_hrd", bus.h_rd, 0);

        op(PUSH, 'h11, 0);
        op(PUSH, 'h22, 0);
        op(PUSH, 'h33, 0);
        chk("push3_rp", bus.rp_o, 3);
        chk("push3_r", bus.r_o, 'h33);

        op(POP, 0, 0);
        chk("pop1_fill_rvld", bus.r_vld, 0);
        chk("pop1_fill_rp", bus.rp_o, 3);
        tick();
        chk("pop1_rvld", bus.r_vld, 1);
        chk("pop1_r", bus.r_o, 'h22);
        chk("pop1_rp", bus.rp_o, 2);
        op(POP, 0, 0);
        chk("pop2_fill_rvld", bus.r_vld, 0);
        tick();
        chk("pop2_r", bus.r_o, 'h11);
        chk("pop2_rp", bus.rp_o, 1);

        op(PUSH, 'h22, 0);
        op(PUSH, 'h33, 0);
        op(LOAD, 0, 0);
        chk("ld0_vld", bus.ld_vld, 1);
        chk("ld0_d", bus.ld_d, 'h33);
        tick();
        chk("ld0_pulse", bus.ld_vld, 0);
        op(LOAD, 0, 1);
        chk("ld1_vld", bus.ld_vld, 1);
        chk("ld1_d", bus.ld_d, 'h22);
        tick();
        chk("ld1_pulse", bus.ld_vld, 0);
        op(LOAD, 0, 2);
        chk("ld2_vld", bus.ld_vld, 1);
        chk("ld2_d", bus.ld_d, 'h11);
        tick();
        chk("ld_unf_before", bus.unf, 0);
        op(LOAD, 0, 3);
        chk("ld3_vld", bus.ld_vld, 1);
        chk("ld3_d", bus.ld_d, 0);
        chk("ld3_unf", bus.unf, 1);
        tick();

        op(PUSH, 'h44, 0);
        op(PUSH, 'h55, 0);
        chk("full_rp", bus.rp_o, 5);
        chk("full_ovf0", bus.ovf, 0);
        op(PUSH, 'h66, 0);
        chk("ovf_flag", bus.ovf, 1);
        chk("ovf_rp", bus.rp_o, 5);
        chk("ovf_r", bus.r_o, 'h55);

        op(POP, 0, 0);
        chk("rstfill_rvld0", bus.r_vld, 0);
        rst = 1'b1;
        tick();
        chk("rstfill_rp", bus.rp_o, 0);
        chk("rstfill_r", bus.r_o, 0);
        chk("rstfill_rvld", bus.r_vld, 1);
        chk("rstfill_flags", {bus.ovf, bus.unf}, 0);
        rst = 1'b0;
        tick();
        chk("rstfill_noack", {bus.ld_vld, bus.h_ack}, 0);
        chk("rstfill_crdy", bus.c_rdy, 1);
        chk("rstfill_rp2", bus.rp_o, 0);

        op(POP, 0, 0);
        chk("popempty_unf", bus.unf, 1);
        chk("popempty_rp", bus.rp_o, 0);
        op(MOVE, 'h77, 0);
        chk("move_empty_rp", bus.rp_o, 1);
        chk("move_empty_r", bus.r_o, 'h77);
        op(MOVE, 'h88, 0);
        chk("move_rp", bus.rp_o, 1);
        chk("move_r", bus.r_o, 'h88);

        bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 0; bus.h_wd = 'hAB;
        #1;
        chk("hw_grant_crdy", bus.c_rdy, 1);
        chk("hw_grant_noack", bus.h_ack, 0);
        tick();
        chk("hw_ack", bus.h_ack, 1);
        chk("hw_host_crdy", bus.c_rdy, 0);
        bus.h_req = 1'b0;
        tick();
        chk("hw_ack_pulse", bus.h_ack, 0);
        bus.h_req = 1'b1; bus.h_we = 1'b0;
        tick();
        chk("hr_ack", bus.h_ack, 1);
        chk("hr_data", bus.h_rd, 'hAB);
        bus.h_req = 1'b0;
        tick();
        chk("hr_ack_pulse", bus.h_ack, 0);
        chk("host_core_rp", bus.rp_o, 1);
        chk("host_core_r", bus.r_o, 'h88);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 0;
        pushed = 0; low_at = -1; ack_at = -1; hrd = '0;
        for (int i = 0; i < 20 && pushed < 5; i++) begin
            bus.c_op = PUSH;
            bus.c_d  = DSZ'(pushed + 1);
            #1;
            acc = bus.c_rdy;
            if (!acc && low_at < 0) low_at = i;
            if (bus.h_ack) begin
                ack_at = i;
                hrd    = bus.h_rd;
            end
            tick();
            if (acc) pushed++;
            if (ack_at == i) bus.h_req = 1'b0;
        end
        bus.c_op  = NOP;
        bus.h_req = 1'b0;
        #1;
        chk("storm_pushed", pushed, 5);
        chk("storm_stall_cycle", low_at, 3);
        chk("storm_ack_cycle", ack_at, 4);
        chk("storm_hrd", hrd, 1);
        chk("storm_rp", bus.rp_o, 5);
        chk("storm_r", bus.r_o, 5);
        op(LOAD, 0, 3);
        chk("storm_ld_vld", bus.ld_vld, 1);
        chk("storm_ld_d", bus.ld_d, 2);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
